note_scheduler: RTL

Sequencer that plays a song out of a song ROM through up to four note_player voices. It fetches 16-bit song words, issues notes to voices over a shared load bus, and advances song time by counting 1/48 s beats. It sits between the song ROM and the note_player instances. It tracks per-voice busy state so a note is never loaded onto a voice that is still sounding.

---
 rtl/note_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - song sequencer that feeds note_player voices from a song ROM
module note_scheduler #(
  parameter int VOICES = 3,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              song_start,
  input  logic [ADDR_W-1:0] song_base,
  input  logic              play,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic [VOICES-1:0] voice_done,
  output logic [VOICES-1:0] load_new_note,
  output logic [5:0]        note_to_load,
  output logic [5:0]        duration_to_load,
  output logic              song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BEATS,
    S_DONE
  } state_t;

  localparam logic [2:0] VOICE_CNT = 3'(VOICES);

  state_t state;
  state_t next_state;

  // Fields of the note being issued, captured while decoding.
  logic [1:0] cur_voice;
  logic [5:0] cur_note;
  logic [5:0] cur_dur;

  logic [5:0] beat_cnt;

  // Per-voice sounding flag and the window in which a stale done flag is ignored.
  logic [VOICES-1:0] busy;
  logic [1:0]        guard [VOICES];

  // Raw decode of the word presented by the ROM.
  logic       rd_is_wait;
  logic [1:0] rd_voice;
  logic [5:0] rd_note;
  logic [5:0] rd_dur;
  logic [5:0] rd_beats;
  logic       rd_voice_ok;

  logic [VOICES-1:0] voice_mask;
  logic              voice_busy;
  logic              issue_fire;
  logic              wait_tick;
  logic              wait_end;
  logic              drop_word;
  logic [ADDR_W-1:0] addr_next;

  assign rd_is_wait  = rom_data[15];
  assign rd_voice    = rom_data[14:13];
  assign rd_note     = rom_data[12:7];
  assign rd_dur      = rom_data[6:1];
  assign rd_beats    = rom_data[5:0];
  assign rd_voice_ok = ({1'b0, rd_voice} < VOICE_CNT);

  assign addr_next = rom_addr + ADDR_W'(1);

  // One-hot select of the voice addressed by the pending note.
  always_comb begin
    voice_mask = '0;
    for (int i = 0; i < VOICES; i++) begin
      voice_mask[i] = (cur_voice == 2'(i));
    end
  end

  assign voice_busy = |(busy & voice_mask);

  // A load only happens when running, the voice is free and no restart/reset overrides it.
  assign issue_fire = (state == S_ISSUE) && play && !voice_busy && !song_start && !reset;
  assign wait_tick  = (state == S_WAIT_BEATS) && beat && play;
  assign wait_end   = wait_tick && (beat_cnt <= 6'd1);
  assign drop_word  = (state == S_DECODE) && !rd_is_wait && !rd_voice_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a song start restarts the fetch loop from any state.
  always_comb begin
    next_state = state;
    if (song_start) begin
      next_state = S_FETCH;
    end else begin
      case (state)
        S_IDLE:   next_state = S_IDLE;
        S_FETCH:  next_state = S_DECODE;
        S_DECODE: begin
          if (rd_is_wait) begin
            next_state = (rd_beats == 6'd0) ? S_DONE : S_WAIT_BEATS;
          end else if (rd_voice_ok) begin
            next_state = S_ISSUE;
          end else begin
            next_state = S_FETCH;
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            next_state = S_FETCH;
          end
        end
        S_WAIT_BEATS: begin
          if (wait_end) begin
            next_state = S_FETCH;
          end
        end
        S_DONE:   next_state = S_DONE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Outputs: load pulse and buses are driven only while a note is pending issue.
  always_comb begin
    load_new_note    = '0;
    note_to_load     = 6'd0;
    duration_to_load = 6'd0;
    song_done        = 1'b0;
    if (state == S_ISSUE) begin
      note_to_load     = cur_note;
      duration_to_load = cur_dur;
    end
    if (issue_fire) begin
      load_new_note = voice_mask;
    end
    if (state == S_DONE) begin
      song_done = 1'b1;
    end
  end

  // ROM address: reload on start, advance after a dropped word, an issued note or a finished wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (song_start) begin
      rom_addr <= song_base;
    end else if (drop_word || issue_fire || wait_end) begin
      rom_addr <= addr_next;
    end
  end

  // Capture the note fields while decoding so the buses stay stable through a stalled issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_voice <= 2'd0;
      cur_note  <= 6'd0;
      cur_dur   <= 6'd0;
    end else if (state == S_DECODE && !rd_is_wait && !song_start) begin
      cur_voice <= rd_voice;
      cur_note  <= rd_note;
      cur_dur   <= rd_dur;
    end
  end

  // Beat counter: loaded when a wait word is decoded, counts only qualifying beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= 6'd0;
    end else if (song_start) begin
      beat_cnt <= 6'd0;
    end else if (state == S_DECODE && rd_is_wait) begin
      beat_cnt <= rd_beats;
    end else if (wait_tick && beat_cnt != 6'd0) begin
      beat_cnt <= beat_cnt - 6'd1;
    end
  end

  // Busy tracking: set on load, cleared by done once the stale-flag window has passed.
  always_ff @(posedge clk) begin
    if (reset || song_start) begin
      busy <= '0;
      for (int i = 0; i < VOICES; i++) begin
        guard[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (issue_fire && voice_mask[i]) begin
          busy[i]  <= 1'b1;
          guard[i] <= 2'd2;
        end else if (guard[i] != 2'd0) begin
          guard[i] <= guard[i] - 2'd1;
        end else if (voice_done[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule
